if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction-fetch stage. Owns the PC and drives the instruction-memory request/response handshake.
- Produces if_to_ic_bus, which the IF→IC pipeline register captures whenever stall[1] is NoStop.
- It is the producer side of that bus: it honours the same stall vector and br_bus redirect that the IC register consumes.
- Supports one outstanding fetch. Discards responses that belong to fetches cancelled by a branch.

Parameters:
- RESET_PC, 32'hbfc00000, first fetch address after reset.
- STALL_WD, 6, width of the stall vector (`StallBus).
- BR_WD, 33, width of br_bus, packed {br_e, br_addr[31:0]}.
- IF_TO_IC_WD, 65, width of the output bus, packed {ce, pc[31:0], inst[31:0]}.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock, asynchronous, active-high.
- stall  in  STALL_WD  pipeline stall vector; stall[1]==`Stop means IC does not capture.
- br_bus  in  BR_WD  {br_e, br_addr}; br_e high for one cycle redirects fetch.
- inst_req  out  1  fetch request valid.
- inst_addr  out  32  fetch address; equals pc.
- inst_addr_ok  in  1  request accepted this cycle.
- inst_data_ok  in  1  read data valid this cycle.
- inst_rdata  in  32  read data.
- if_to_ic_bus  out  IF_TO_IC_WD  {ce, pc, inst} to the IC register.
- stallreq_if  out  1  high while no usable instruction is presented.

Behaviour:
- Registers:
  - state: IDLE, REQ, WAIT, HOLD.
  - pc (32): reset to RESET_PC.
  - discard (1) and redirect_pc (32): both reset to 0.
  - inst_hold (32): reset to 0.
- Reset values: state=IDLE, inst_req=0, if_to_ic_bus=0, stallreq_if=1.
- Reset asserted mid-operation drops everything immediately. Any later inst_data_ok for the abandoned fetch arrives in IDLE or REQ and is ignored.
- next_pc = pc+4, modulo 2^32. 32'hfffffffc wraps to 0.
- IDLE → REQ on the next clock. pc is unchanged.
- REQ:
  - inst_req=1, inst_addr=pc. Address and req stay stable until inst_addr_ok.
  - inst_addr_ok=1 → WAIT.
  - br_e=1 in the same cycle as inst_addr_ok → WAIT with discard←1 and redirect_pc←br_addr.
  - br_e=1 without inst_addr_ok → stay in REQ with the same address; discard←1, redirect_pc←br_addr.
  - A later br_e overwrites redirect_pc.
- WAIT (inst_req=0):
  - inst_data_ok with discard=1: drop the data; pc←redirect_pc; discard←0; → REQ. Output ce=0.
  - inst_data_ok with discard=0: present {1, pc, inst_rdata} combinationally this cycle, with ce gated by !br_e. Then:
    - br_e=1 → pc←br_addr, → REQ.
    - else stall[1]==`NoStop → pc←next_pc, → REQ.
    - else inst_hold←inst_rdata, → HOLD.
  - No inst_data_ok and br_e=1 → discard←1, redirect_pc←br_addr.
- HOLD:
  - Present {!br_e, pc, inst_hold}.
  - br_e=1 → pc←br_addr, → REQ.
  - else stall[1]==`NoStop → pc←next_pc, → REQ.
  - else stay.
- Output rules:
  - ce=0 in IDLE, in REQ, and in WAIT cycles without a usable response; pc and inst fields are then don't-care but driven to 0.
  - stallreq_if = !ce, except that it is 0 whenever br_e=1, so the redirect is never blocked.
- Limits and protocol errors:
  - At most one request is outstanding. inst_req is never high in WAIT or HOLD.
  - inst_data_ok outside WAIT and inst_addr_ok outside REQ are ignored.
- Latency:
  - Zero-wait memory (addr_ok in the first REQ cycle, data_ok in the next cycle): one instruction every 2 cycles.
  - Branch redirect: the first fetch of br_addr is issued the cycle after br_e, or after the discarded response returns.

Test Plan:
1. Reset release; memory with addr_ok immediate and data_ok 1 cycle later; stall=0 → inst_addr sequence bfc00000, bfc00004, bfc00008. ce pulses with matching pc/inst every 2 cycles; stallreq_if low only on ce cycles.
2. stall[1]=1 for 3 cycles while data_ok returns inst 32'h24010001 at pc bfc00004 → HOLD. if_to_ic_bus holds {1, bfc00004, 24010001} for all stalled cycles; no new inst_req. Next fetch is bfc00008 after the stall clears.
3. br_e=1, br_addr=80001000 while in WAIT for bfc00010 → the returning data is dropped (ce=0). Next inst_req has addr 80001000.
4. br_e=1 (br_addr=80002000) in REQ with addr_ok held low for 2 cycles → inst_addr stays bfc00000 until accepted. Its response is discarded; next request is 80002000.
5. pc=fffffffc, stall=0 → after delivery, next inst_addr=00000000.
6. rst asserted asynchronously during WAIT, with a stale data_ok arriving 1 cycle after release → inst_req=0 and if_to_ic_bus=0 immediately. Stale data_ok is ignored; first new request is RESET_PC.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, runs the single-outstanding imem handshake
// and produces the {ce, pc, inst} bus captured by the IF->IC pipeline register.
module if_fetch #(
   parameter logic [31:0] RESET_PC    = 32'hbfc00000,
   parameter int          STALL_WD    = 6,
   parameter int          BR_WD       = 33,
   parameter int          IF_TO_IC_WD = 65
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [STALL_WD-1:0]    stall,
   input  logic [BR_WD-1:0]       br_bus,
   output logic                   inst_req,
   output logic [31:0]            inst_addr,
   input  logic                   inst_addr_ok,
   input  logic                   inst_data_ok,
   input  logic [31:0]            inst_rdata,
   output logic [IF_TO_IC_WD-1:0] if_to_ic_bus,
   output logic                   stallreq_if
);

   localparam logic STOP = 1'b1;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_e;

   state_e      state_q;
   logic [31:0] pc_q;
   logic [31:0] redirect_pc_q;
   logic [31:0] inst_hold_q;
   logic        discard_q;

   logic        br_e;
   logic [31:0] br_addr;
   logic [31:0] next_pc;
   logic        ic_stop;
   logic        unused_stall;

   assign br_e         = br_bus[BR_WD-1];
   assign br_addr      = br_bus[31:0];
   assign next_pc      = pc_q + 32'd4;
   assign ic_stop      = (stall[1] == STOP);
   assign unused_stall = ^stall;

   assign inst_req  = (state_q == REQ);
   assign inst_addr = pc_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         pc_q          <= RESET_PC;
         discard_q     <= 1'b0;
         redirect_pc_q <= 32'h0;
         inst_hold_q   <= 32'h0;
      end else begin
         case (state_q)
            IDLE: state_q <= REQ;
            REQ: begin
               // The request already on the bus must complete; its answer is dropped later.
               if (br_e) begin
                  discard_q     <= 1'b1;
                  redirect_pc_q <= br_addr;
               end
               if (inst_addr_ok) state_q <= WAIT;
            end
            WAIT: begin
               if (inst_data_ok) begin
                  state_q <= REQ;
                  if (discard_q) begin
                     discard_q <= 1'b0;
                     pc_q      <= br_e ? br_addr : redirect_pc_q;
                  end else if (br_e) begin
                     pc_q <= br_addr;
                  end else if (!ic_stop) begin
                     pc_q <= next_pc;
                  end else begin
                     inst_hold_q <= inst_rdata;
                     state_q     <= HOLD;
                  end
               end else if (br_e) begin
                  discard_q     <= 1'b1;
                  redirect_pc_q <= br_addr;
               end
            end
            HOLD: begin
               if (br_e) begin
                  pc_q    <= br_addr;
                  state_q <= REQ;
               end else if (!ic_stop) begin
                  pc_q    <= next_pc;
                  state_q <= REQ;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   logic        ce;
   logic [31:0] out_pc;
   logic [31:0] out_inst;

   always_comb begin
      ce       = 1'b0;
      out_pc   = 32'h0;
      out_inst = 32'h0;
      case (state_q)
         WAIT: if (inst_data_ok && !discard_q) begin
            ce       = !br_e;
            out_pc   = pc_q;
            out_inst = inst_rdata;
         end
         HOLD: begin
            ce       = !br_e;
            out_pc   = pc_q;
            out_inst = inst_hold_q;
         end
         default: ;
      endcase
   end

   assign if_to_ic_bus = IF_TO_IC_WD'({ce, out_pc, out_inst});
   // A redirect must never be held back by a missing instruction.
   assign stallreq_if  = br_e ? 1'b0 : !ce;

endmodule

// File: tb/tb_if_fetch.sv
// Directed, table-driven bench for if_fetch: one vector per clock cycle.
module tb_if_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  stall = '0;
   logic [32:0] br_bus = '0;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok = 1'b0;
   logic        inst_data_ok = 1'b0;
   logic [31:0] inst_rdata = '0;
   logic [64:0] if_to_ic_bus;
   logic        stallreq_if;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   if_fetch dut (
      .clk(clk), .rst(rst), .stall(stall), .br_bus(br_bus),
      .inst_req(inst_req), .inst_addr(inst_addr),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
      .inst_rdata(inst_rdata), .if_to_ic_bus(if_to_ic_bus),
      .stallreq_if(stallreq_if)
   );

   typedef struct {
      logic        stl;
      logic        bre;
      logic [31:0] bra;
      logic        aok;
      logic        dok;
      logic [31:0] rd;
      logic        req;
      logic [31:0] addr;
      logic [64:0] bus;
      logic        sr;
   } vec_t;

   vec_t t1[$];
   vec_t t2[$];

   function automatic vec_t mk(logic stl, logic bre, logic [31:0] bra, logic aok, logic dok,
                               logic [31:0] rd, logic req, logic [31:0] addr,
                               logic ce, logic [31:0] pc, logic [31:0] inst, logic sr);
      vec_t v;
      v.stl = stl; v.bre = bre; v.bra = bra; v.aok = aok; v.dok = dok; v.rd = rd;
      v.req = req; v.addr = addr; v.bus = {ce, pc, inst}; v.sr = sr;
      return v;
   endfunction

   task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   // Called at a negedge: drive, let comb settle, compare, advance to next negedge.
   task automatic apply(input string tag, input int idx, input vec_t v);
      stall        = {4'b0, v.stl, 1'b0};
      br_bus       = {v.bre, v.bra};
      inst_addr_ok = v.aok;
      inst_data_ok = v.dok;
      inst_rdata   = v.rd;
      #1;
      chk($sformatf("%s[%0d].req", tag, idx), 65'(inst_req), 65'(v.req));
      chk($sformatf("%s[%0d].addr", tag, idx), 65'(inst_addr), 65'(v.addr));
      chk($sformatf("%s[%0d].bus", tag, idx), if_to_ic_bus, v.bus);
      chk($sformatf("%s[%0d].sr", tag, idx), 65'(stallreq_if), 65'(v.sr));
      @(negedge clk);
   endtask

   initial begin
      //              stl bre bra           aok dok rd            req addr          ce pc            inst          sr
      // Zero-wait fetches, then a 3-cycle IC stall while holding bfc00004
      t1.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'hbfc00000, 0, 32'h0,        32'h0,        1)); // IDLE
      t1.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'hbfc00000, 0, 32'h0,        32'h0,        1));
      t1.push_back(mk(0, 0, 32'h0,        0, 1, 32'h11111111, 0, 32'hbfc00000, 1, 32'hbfc00000, 32'h11111111, 0));
      t1.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'hbfc00004, 0, 32'h0,        32'h0,        1));
      t1.push_back(mk(1, 0, 32'h0,        0, 1, 32'h24010001, 0, 32'hbfc00004, 1, 32'hbfc00004, 32'h24010001, 0));
      t1.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'hbfc00004, 1, 32'hbfc00004, 32'h24010001, 0)); // HOLD
      t1.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'hbfc00004, 1, 32'hbfc00004, 32'h24010001, 0));
      t1.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'hbfc00004, 1, 32'hbfc00004, 32'h24010001, 0));
      t1.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'hbfc00008, 0, 32'h0,        32'h0,        1));
      t1.push_back(mk(0, 0, 32'h0,        0, 1, 32'h22222222, 0, 32'hbfc00008, 1, 32'hbfc00008, 32'h22222222, 0));
      t1.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'hbfc0000c, 0, 32'h0,        32'h0,        1));
      t1.push_back(mk(0, 0, 32'h0,        0, 1, 32'h33333333, 0, 32'hbfc0000c, 1, 32'hbfc0000c, 32'h33333333, 0));
      // Branch while waiting on bfc00010: response dropped, refetch 80001000
      t1.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'hbfc00010, 0, 32'h0,        32'h0,        1));
      t1.push_back(mk(0, 1, 32'h80001000, 0, 0, 32'h0,        0, 32'hbfc00010, 0, 32'h0,        32'h0,        0));
      t1.push_back(mk(0, 0, 32'h0,        0, 1, 32'h44444444, 0, 32'hbfc00010, 0, 32'h0,        32'h0,        1));
      t1.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h80001000, 0, 32'h0,        32'h0,        1));
      t1.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h80001000, 0, 32'h0,        32'h0,        1));
      // Branch alongside a live response: ce gated, redirect to fffffffc
      t1.push_back(mk(0, 1, 32'hfffffffc, 0, 1, 32'h55555555, 0, 32'h80001000, 0, 32'h80001000, 32'h55555555, 0));
      t1.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'hfffffffc, 0, 32'h0,        32'h0,        1));
      t1.push_back(mk(0, 0, 32'h0,        0, 1, 32'h66666666, 0, 32'hfffffffc, 1, 32'hfffffffc, 32'h66666666, 0));
      t1.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h00000000, 0, 32'h0,        32'h0,        1)); // wrapped

      // After mid-WAIT reset: stale data_ok ignored, branch in REQ with addr_ok low twice
      t2.push_back(mk(0, 0, 32'h0,        0, 1, 32'h88888888, 0, 32'hbfc00000, 0, 32'h0,        32'h0,        1)); // IDLE
      t2.push_back(mk(0, 1, 32'h80002000, 0, 1, 32'h88888888, 1, 32'hbfc00000, 0, 32'h0,        32'h0,        0));
      t2.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'hbfc00000, 0, 32'h0,        32'h0,        1));
      t2.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'hbfc00000, 0, 32'h0,        32'h0,        1));
      t2.push_back(mk(0, 0, 32'h0,        0, 1, 32'h99999999, 0, 32'hbfc00000, 0, 32'h0,        32'h0,        1));
      t2.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h80002000, 0, 32'h0,        32'h0,        1));

      // Reset state while rst is held
      @(negedge clk);
      chk("rst.req", 65'(inst_req), 65'(1'b0));
      chk("rst.bus", if_to_ic_bus, 65'h0);
      chk("rst.sr", 65'(stallreq_if), 65'(1'b1));
      chk("rst.addr", 65'(inst_addr), 65'(32'hbfc00000));
      rst = 1'b0;

      foreach (t1[i]) apply("t1", i, t1[i]);

      // Now in WAIT for pc 0; a live response is visible until reset lands mid-cycle
      stall = '0; br_bus = '0; inst_addr_ok = 1'b0;
      inst_data_ok = 1'b1; inst_rdata = 32'h77777777;
      #1;
      chk("pre_rst.bus", if_to_ic_bus, {1'b1, 32'h0, 32'h77777777});
      #1 rst = 1'b1;
      #1;
      chk("async_rst.req", 65'(inst_req), 65'(1'b0));
      chk("async_rst.bus", if_to_ic_bus, 65'h0);
      chk("async_rst.sr", 65'(stallreq_if), 65'(1'b1));
      chk("async_rst.addr", 65'(inst_addr), 65'(32'hbfc00000));
      @(negedge clk);
      rst = 1'b0;

      foreach (t2[i]) apply("t2", i, t2[i]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
